// File: rtl/inst_fetcher.sv
// Instruction fetcher: requests an instruction, hands it to the predictor, then issues it.
// It follows the predicted target and redirects on a ROB flush.
module inst_fetcher #(
    parameter int          ADDR_BITS = 17,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic [31:0] Target_PC,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Valid,
    input  logic [31:0] Mem_Inst,
    output logic [31:0] PC,
    output logic [31:0] Inst,
    output logic        Ready,
    input  logic [31:0] Predict_Jump,
    input  logic        Predict_Jump_Bool,
    output logic        Issue_Valid,
    output logic [31:0] Issue_PC,
    output logic [31:0] Issue_Inst,
    output logic        Issue_Pred,
    input  logic        Issue_Full
);

    typedef enum logic [1:0] {
        START,
        WAIT,
        PRED,
        ISSUE
    } state_t;

    localparam logic [31:0] ADDR_MASK = (ADDR_BITS >= 32) ? 32'hFFFF_FFFF :
                                        32'((64'h1 << ADDR_BITS) - 64'h1);

    function automatic logic [31:0] maskAddr(input logic [31:0] addr);
        return addr & ADDR_MASK;
    endfunction

    state_t      r_state,    w_state;
    logic [31:0] r_pcReg,    w_pcReg;
    logic [31:0] r_instLat,  w_instLat;
    logic [31:0] r_predTgt,  w_predTgt;
    logic        r_predBool, w_predBool;

    logic        w_memReq;
    logic [31:0] w_memAddr;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic        w_ready;
    logic        w_issueValid;
    logic [31:0] w_issuePc;
    logic [31:0] w_issueInst;
    logic        w_issuePred;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= START;
        end else begin
            r_state <= w_state;
        end
    end

    // Everything holds unless a live (rdy=1) cycle says otherwise; a flush outranks the state.
    always_comb begin
        w_state      = r_state;
        w_pcReg      = r_pcReg;
        w_instLat    = r_instLat;
        w_predTgt    = r_predTgt;
        w_predBool   = r_predBool;
        w_memReq     = Mem_Req;
        w_memAddr    = Mem_Addr;
        w_pc         = PC;
        w_inst       = Inst;
        w_ready      = Ready;
        w_issueValid = Issue_Valid;
        w_issuePc    = Issue_PC;
        w_issueInst  = Issue_Inst;
        w_issuePred  = Issue_Pred;

        if (rdy) begin
            w_issueValid = 1'b0;
            if (clr) begin
                w_pcReg    = maskAddr(Target_PC);
                w_memAddr  = maskAddr(Target_PC);
                w_memReq   = 1'b1;
                w_ready    = 1'b0;
                w_predBool = 1'b0;
                w_predTgt  = 32'h0;
                w_state    = WAIT;
            end else begin
                case (r_state)
                    START: begin
                        w_memReq  = 1'b1;
                        w_memAddr = r_pcReg;
                        w_state   = WAIT;
                    end
                    WAIT: begin
                        if (Mem_Valid) begin
                            w_instLat = Mem_Inst;
                            w_pc      = r_pcReg;
                            w_inst    = Mem_Inst;
                            w_ready   = 1'b1;
                            w_memReq  = 1'b0;
                            w_state   = PRED;
                        end
                    end
                    PRED: begin
                        w_ready    = 1'b0;
                        w_predTgt  = maskAddr(Predict_Jump);
                        w_predBool = Predict_Jump_Bool;
                        w_state    = ISSUE;
                    end
                    ISSUE: begin
                        if (!Issue_Full) begin
                            w_issueValid = 1'b1;
                            w_issuePc    = r_pcReg;
                            w_issueInst  = r_instLat;
                            w_issuePred  = r_predBool;
                            w_pcReg      = r_predTgt;
                            w_memAddr    = r_predTgt;
                            w_memReq     = 1'b1;
                            w_state      = WAIT;
                        end else begin
                            w_memReq = 1'b0;
                        end
                    end
                    default: w_state = START;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcReg     <= maskAddr(RESET_PC);
            r_instLat   <= 32'h0;
            r_predTgt   <= 32'h0;
            r_predBool  <= 1'b0;
            Mem_Req     <= 1'b0;
            Mem_Addr    <= 32'h0;
            PC          <= 32'h0;
            Inst        <= 32'h0;
            Ready       <= 1'b0;
            Issue_Valid <= 1'b0;
            Issue_PC    <= 32'h0;
            Issue_Inst  <= 32'h0;
            Issue_Pred  <= 1'b0;
        end else begin
            r_pcReg     <= w_pcReg;
            r_instLat   <= w_instLat;
            r_predTgt   <= w_predTgt;
            r_predBool  <= w_predBool;
            Mem_Req     <= w_memReq;
            Mem_Addr    <= w_memAddr;
            PC          <= w_pc;
            Inst        <= w_inst;
            Ready       <= w_ready;
            Issue_Valid <= w_issueValid;
            Issue_PC    <= w_issuePc;
            Issue_Inst  <= w_issueInst;
            Issue_Pred  <= w_issuePred;
        end
    end

endmodule
